// File: rtl/thread_scheduler.sv
// thread_scheduler: hardware thread context manager with round-robin issue.
//
// Tracks a FREE/ACTIVE/SLEEP state per thread context, applies one
// thread-control command per cycle (sleep/wake/kill), allocates the
// lowest-index FREE thread on init_req and picks the next ACTIVE thread
// to issue in round-robin order.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   stall             freezes issue selection (commands/init still apply)
//   cmd_valid         thread-control command present
//   trd_ctrl[1:0]     01 sleep cmd_tid, 10 wake tgt_tid, 11 kill tgt_tid
//   cmd_tid, tgt_tid  issuing thread id, target thread id
//   init_req          allocate a new thread
//   issue_valid/tid   registered issue selection
//   init_ack/fail/tid registered allocation result (one-cycle pulses)
//   thread_state      2 bits per thread, thread i at [2i+1:2i]
//   idle              all threads FREE (combinational from thread_state)
//   active_cnt        registered ACTIVE-thread count, only when the
//                     THREAD_ACTIVE_CNT_EN macro is defined
module thread_scheduler #(
    parameter int unsigned NUM_THREADS = 8,
    parameter int unsigned TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     cmd_valid,
    input  logic [1:0]               trd_ctrl,
    input  logic [TID_W-1:0]         cmd_tid,
    input  logic [TID_W-1:0]         tgt_tid,
    input  logic                     init_req,
    output logic                     issue_valid,
    output logic [TID_W-1:0]         issue_tid,
    output logic                     init_ack,
    output logic                     init_fail,
    output logic [TID_W-1:0]         init_tid,
    output logic [2*NUM_THREADS-1:0] thread_state,
    output logic                     idle
`ifdef THREAD_ACTIVE_CNT_EN
    ,
    output logic [TID_W:0]           active_cnt
`endif
);

    localparam logic [1:0] ST_FREE   = 2'b00;
    localparam logic [1:0] ST_ACTIVE = 2'b01;
    localparam logic [1:0] ST_SLEEP  = 2'b10;

    localparam logic [1:0] CMD_SLEEP = 2'b01;
    localparam logic [1:0] CMD_WAKE  = 2'b10;
    localparam logic [1:0] CMD_KILL  = 2'b11;

    // Reset: thread 0 ACTIVE, everything else FREE.
    localparam logic [2*NUM_THREADS-1:0] RESET_STATE = (2*NUM_THREADS)'(1);

    logic [NUM_THREADS-1:0][1:0] state_q;
    logic [NUM_THREADS-1:0][1:0] state_d;
    logic [NUM_THREADS-1:0]      kill_hit;
    logic [TID_W-1:0]            ptr_q;
    logic [TID_W-1:0]            ptr_d;
    logic                        alloc_found;
    logic [TID_W-1:0]            alloc_tid;
    logic                        rr_found;
    logic [TID_W-1:0]            rr_tid;
    logic [TID_W-1:0]            rr_idx;
    logic                        issue_valid_d;
    logic [TID_W-1:0]            issue_tid_d;
    logic                        init_ack_d;
    logic                        init_fail_d;
    logic [TID_W-1:0]            init_tid_d;
`ifdef THREAD_ACTIVE_CNT_EN
    logic [TID_W:0]              cnt_d;
`endif

    assign thread_state = state_q;
    assign idle         = (state_q == '0);

    // Next-state: command first, then allocation, then issue selection on
    // the post-command/post-allocation state.
    always_comb begin
        state_d       = state_q;
        kill_hit      = '0;
        alloc_found   = 1'b0;
        alloc_tid     = '0;
        rr_found      = 1'b0;
        rr_tid        = ptr_q;
        rr_idx        = '0;
        ptr_d         = ptr_q;
        issue_valid_d = issue_valid;
        issue_tid_d   = issue_tid;
        init_ack_d    = 1'b0;
        init_fail_d   = 1'b0;
        init_tid_d    = '0;
`ifdef THREAD_ACTIVE_CNT_EN
        cnt_d         = '0;
`endif

        if (cmd_valid) begin
            unique case (trd_ctrl)
                CMD_SLEEP: if (state_q[cmd_tid] == ST_ACTIVE) state_d[cmd_tid] = ST_SLEEP;
                CMD_WAKE:  if (state_q[tgt_tid] == ST_SLEEP)  state_d[tgt_tid] = ST_ACTIVE;
                CMD_KILL: begin
                    state_d[tgt_tid]  = ST_FREE;
                    kill_hit[tgt_tid] = 1'b1;
                end
                default: ;
            endcase
        end

        // Lowest FREE thread in the current cycle; a kill target only
        // becomes FREE at the edge, so it is not yet eligible.
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            if (!alloc_found && state_q[i] == ST_FREE && !kill_hit[i]) begin
                alloc_found = 1'b1;
                alloc_tid   = TID_W'(i);
            end
        end

        if (init_req) begin
            if (alloc_found) begin
                state_d[alloc_tid] = ST_ACTIVE;
                init_ack_d         = 1'b1;
                init_tid_d         = alloc_tid;
            end else begin
                init_fail_d = 1'b1;
            end
        end

        // Round-robin search starting after the pointer; k == NUM_THREADS
        // wraps back onto the pointer itself (single ACTIVE thread case).
        for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
            rr_idx = ptr_q + TID_W'(k);
            if (!rr_found && state_d[rr_idx] == ST_ACTIVE) begin
                rr_found = 1'b1;
                rr_tid   = rr_idx;
            end
        end

        if (stall) begin
            // Held selection is invalidated if its thread leaves ACTIVE.
            issue_valid_d = issue_valid && (state_d[issue_tid] == ST_ACTIVE);
        end else if (rr_found) begin
            issue_valid_d = 1'b1;
            issue_tid_d   = rr_tid;
            ptr_d         = rr_tid;
        end else begin
            issue_valid_d = 1'b0;
        end

`ifdef THREAD_ACTIVE_CNT_EN
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            if (state_d[i] == ST_ACTIVE) cnt_d = cnt_d + (TID_W+1)'(1);
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            ptr_q       <= TID_W'(NUM_THREADS - 1);
            issue_valid <= 1'b0;
            issue_tid   <= '0;
            init_ack    <= 1'b0;
            init_fail   <= 1'b0;
            init_tid    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            issue_valid <= issue_valid_d;
            issue_tid   <= issue_tid_d;
            init_ack    <= init_ack_d;
            init_fail   <= init_fail_d;
            init_tid    <= init_tid_d;
        end
    end

`ifdef THREAD_ACTIVE_CNT_EN
    // ACTIVE-thread count, tracks thread_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) active_cnt <= (TID_W+1)'(1);
        else     active_cnt <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: scoreboard bench for thread_scheduler (8 threads).
// A behavioural reference model computes the expected registered outputs
// each cycle; they are queued when inputs are driven and popped/compared
// one time unit after the following rising edge.
module tb_thread_scheduler;

    localparam int unsigned NT = 8;
    localparam int unsigned TW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          cmd_valid;
    logic [1:0]    trd_ctrl;
    logic [TW-1:0] cmd_tid;
    logic [TW-1:0] tgt_tid;
    logic          init_req;
    logic          issue_valid;
    logic [TW-1:0] issue_tid;
    logic          init_ack;
    logic          init_fail;
    logic [TW-1:0] init_tid;
    logic [2*NT-1:0] thread_state;
    logic          idle;
`ifdef THREAD_ACTIVE_CNT_EN
    logic [TW:0]   active_cnt;
`endif

    thread_scheduler #(.NUM_THREADS(NT), .TID_W(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .cmd_valid    (cmd_valid),
        .trd_ctrl     (trd_ctrl),
        .cmd_tid      (cmd_tid),
        .tgt_tid      (tgt_tid),
        .init_req     (init_req),
        .issue_valid  (issue_valid),
        .issue_tid    (issue_tid),
        .init_ack     (init_ack),
        .init_fail    (init_fail),
        .init_tid     (init_tid),
        .thread_state (thread_state),
        .idle         (idle)
`ifdef THREAD_ACTIVE_CNT_EN
        ,
        .active_cnt   (active_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic [1:0]    m_st [NT];
    logic [TW-1:0] m_ptr;
    logic          m_iv;
    logic [TW-1:0] m_itid;
    logic          m_ack;
    logic          m_fail;
    logic [TW-1:0] m_init;

    typedef struct {
        logic          iv;
        logic [TW-1:0] itid;
        logic          ack;
        logic          fail;
        logic [TW-1:0] init;
        logic [2*NT-1:0] ts;
        logic          idle;
        int            cnt;
    } exp_t;

    exp_t sb[$];

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_st[i] = 2'b00;
        m_st[0] = 2'b01;
        m_ptr   = TW'(NT - 1);
        m_iv    = 1'b0;
        m_itid  = '0;
        m_ack   = 1'b0;
        m_fail  = 1'b0;
        m_init  = '0;
    endtask

    task automatic model_step(input logic st, input logic cv, input logic [1:0] ctl,
                              input logic [TW-1:0] ct, input logic [TW-1:0] tt, input logic ir);
        logic [1:0] nx [NT];
        logic found;
        int   j;
        for (int i = 0; i < NT; i++) nx[i] = m_st[i];
        if (cv) begin
            if (ctl == 2'b01 && m_st[ct] == 2'b01) nx[ct] = 2'b10;
            if (ctl == 2'b10 && m_st[tt] == 2'b10) nx[tt] = 2'b01;
            if (ctl == 2'b11) nx[tt] = 2'b00;
        end
        m_ack = 1'b0; m_fail = 1'b0; m_init = '0;
        if (ir) begin
            found = 1'b0;
            for (int i = 0; i < NT; i++) begin
                if (!found && m_st[i] == 2'b00 && !(cv && ctl == 2'b11 && int'(tt) == i)) begin
                    found = 1'b1; nx[i] = 2'b01; m_init = TW'(i);
                end
            end
            m_ack = found; m_fail = !found;
        end
        if (st) begin
            m_iv = m_iv && (nx[m_itid] == 2'b01);
        end else begin
            found = 1'b0;
            for (int k = 1; k <= NT; k++) begin
                j = (int'(m_ptr) + k) % NT;
                if (!found && nx[j] == 2'b01) begin
                    found = 1'b1; m_itid = TW'(j); m_ptr = TW'(j);
                end
            end
            m_iv = found;
        end
        for (int i = 0; i < NT; i++) m_st[i] = nx[i];
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.iv = m_iv; e.itid = m_itid; e.ack = m_ack; e.fail = m_fail; e.init = m_init;
        e.ts = '0; e.cnt = 0;
        for (int i = 0; i < NT; i++) begin
            e.ts[2*i +: 2] = m_st[i];
            if (m_st[i] == 2'b01) e.cnt++;
        end
        e.idle = (e.ts == '0);
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        check("sb_level", 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("issue_valid", 32'(issue_valid), 32'(e.iv));
        check("issue_tid", 32'(issue_tid), 32'(e.itid));
        check("init_ack", 32'(init_ack), 32'(e.ack));
        check("init_fail", 32'(init_fail), 32'(e.fail));
        check("init_tid", 32'(init_tid), 32'(e.init));
        check("thread_state", 32'(thread_state), 32'(e.ts));
        check("idle", 32'(idle), 32'(e.idle));
`ifdef THREAD_ACTIVE_CNT_EN
        check("active_cnt", 32'(active_cnt), 32'(e.cnt));
`endif
    endtask

    // One clock cycle: drive at negedge, queue model result, compare after edge.
    task automatic cyc(input logic st, input logic cv, input logic [1:0] ctl,
                       input logic [TW-1:0] ct, input logic [TW-1:0] tt, input logic ir);
        @(negedge clk);
        stall = st; cmd_valid = cv; trd_ctrl = ctl; cmd_tid = ct; tgt_tid = tt; init_req = ir;
        model_step(st, cv, ctl, ct, tt, ir);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(thread_state), 32'h0001);
        check({tag, "_iv"}, 32'(issue_valid), 32'd0);
        check({tag, "_itid"}, 32'(issue_tid), 32'd0);
        check({tag, "_ack"}, 32'(init_ack), 32'd0);
        check({tag, "_fail"}, 32'(init_fail), 32'd0);
        check({tag, "_itd"}, 32'(init_tid), 32'd0);
        check({tag, "_idle"}, 32'(idle), 32'd0);
    endtask

    initial begin
        logic [1:0] c;
        rst = 1'b1; stall = 1'b0; cmd_valid = 1'b0; trd_ctrl = 2'b00;
        cmd_tid = '0; tgt_tid = '0; init_req = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        // Thread 0 alone issues every cycle.
        nop(3);
        // Three allocations then rotation.
        cyc(0, 0, 2'b00, 0, 0, 1);
        cyc(0, 0, 2'b00, 0, 0, 1);
        cyc(0, 0, 2'b00, 0, 0, 1);
        nop(5);
        // Fill all eight, then one allocation must fail.
        for (int i = 0; i < 4; i++) cyc(0, 0, 2'b00, 0, 0, 1);
        cyc(0, 0, 2'b00, 0, 0, 1);
        check("full_fail", 32'(init_fail), 32'd1);
        // Back to threads 0-3, sleep 2, wake 2, wake FREE 5.
        for (int i = 4; i < 8; i++) cyc(0, 1, 2'b11, 0, TW'(i), 0);
        cyc(0, 1, 2'b01, 2, 0, 0);
        nop(5);
        cyc(0, 1, 2'b10, 0, 2, 0);
        nop(4);
        cyc(0, 1, 2'b10, 0, 5, 0);
        check("wake_free", 32'(thread_state), 32'h0055);
        nop(2);
        // Stall while thread 1 is held, then kill it.
        for (int n = 0; n < 8 && !(m_iv && m_itid == 1); n++) nop(1);
        cyc(1, 1, 2'b11, 0, 1, 0);
        check("stall_kill_iv", 32'(issue_valid), 32'd0);
        check("stall_kill_st1", 32'(thread_state[3:2]), 32'd0);
        cyc(1, 0, 2'b00, 0, 0, 0);
        nop(3);
        // Re-allocate 1, then kill 3 together with init: must get 4.
        cyc(0, 0, 2'b00, 0, 0, 1);
        cyc(0, 1, 2'b11, 0, 3, 1);
        check("kill_init_tid", 32'(init_tid), 32'd4);
        nop(2);
        // Asynchronous reset in the middle of a command cycle.
        @(negedge clk);
        cmd_valid = 1'b1; trd_ctrl = 2'b11; tgt_tid = 0; init_req = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0; trd_ctrl = 2'b00; init_req = 1'b0;
        nop(2);

        // Random traffic; kills are kept rare so the pool stays populated.
        for (int n = 0; n < 400; n++) begin
            c = 2'($urandom_range(0, 3));
            if (c == 2'b11 && $urandom_range(0, 2) != 0) c = 2'b10;
            cyc(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), c,
                TW'($urandom_range(0, NT - 1)), TW'($urandom_range(0, NT - 1)),
                ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 Parameter NUM_THREADS, default 8, number of hardware thread contexts (power of two, 2..16).
REQ-002 Parameter TID_W, default $clog2(NUM_THREADS), thread-id width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  pipeline stall; freezes issue selection.
REQ-006 cmd_valid  input  1  thread-control command present this cycle.
REQ-007 trd_ctrl  input  2  command: 01 sleep, 10 wake, 11 kill, 00 none.
REQ-008 cmd_tid  input  TID_W  id of the thread executing the command.
REQ-009 tgt_tid  input  TID_W  target thread id for wake/kill.
REQ-010 init_req  input  1  request to allocate a new thread.
REQ-011 issue_valid  output  1  issue_tid is a valid ACTIVE thread.
REQ-012 issue_tid  output  TID_W  thread selected to fetch/issue.
REQ-013 init_ack  output  1  one-cycle pulse: allocation succeeded.
REQ-014 init_fail  output  1  one-cycle pulse: no FREE thread.
REQ-015 init_tid  output  TID_W  allocated id (0 when init_fail).
REQ-016 thread_state  output  2*NUM_THREADS  per-thread state, 2 bits each, thread i at [2i+1:2i].
REQ-017 idle  output  1  all threads FREE.

Function
REQ-018 Per-thread state encoding: 00 FREE, 01 ACTIVE, 10 SLEEP; 11 is never produced.
REQ-019 Sleep (01) moves cmd_tid from ACTIVE to SLEEP; otherwise no effect.
REQ-020 Wake (10) moves tgt_tid from SLEEP to ACTIVE; wake on ACTIVE or FREE has no effect.
REQ-021 Kill (11) moves tgt_tid from any state to FREE; self-kill (tgt_tid == cmd_tid) is legal.
REQ-022 trd_ctrl 00 with cmd_valid, or cmd_valid low, leaves all states unchanged.
REQ-023 Commands take effect at the next rising edge; thread_state is registered.
REQ-024 init_req allocates the lowest-index thread FREE in the current cycle, set ACTIVE at the next edge; init_ack and init_tid registered, valid the following cycle.
REQ-025 init_req with no FREE thread: init_fail pulses one cycle, init_tid = 0, no state change.
REQ-026 A thread being killed in the same cycle as init_req is not eligible for allocation in that cycle.
REQ-027 Issue selection is round-robin: the next ACTIVE thread after the last issued id, wrapping NUM_THREADS-1 -> 0, evaluated on next-state (post-command) values.
REQ-028 issue_valid/issue_tid are registered; a thread slept or killed at edge N is never issued at or after edge N.
REQ-029 A single ACTIVE thread is issued every non-stalled cycle.
REQ-030 No ACTIVE thread: issue_valid = 0, issue_tid holds the last value, round-robin pointer unchanged.
REQ-031 stall = 1: issue outputs and pointer hold; commands and init still apply; if the held thread leaves ACTIVE, issue_valid drops to 0 at the next edge.
REQ-032 idle is combinational from thread_state.

Reset
REQ-033 On rst: thread 0 ACTIVE, all other threads FREE; round-robin pointer = NUM_THREADS-1.
REQ-034 On rst: issue_valid = 0, issue_tid = 0, init_ack = 0, init_fail = 0, init_tid = 0.
REQ-035 Reset asserted mid-operation discards pending commands and allocations immediately; first issue after release is thread 0 on the first edge.

Configuration
REQ-036 Macro THREAD_ACTIVE_CNT_EN defined: extra output active_cnt (TID_W+1 bits), registered count of ACTIVE threads, reset 1, updated with thread_state.
REQ-037 Macro THREAD_ACTIVE_CNT_EN undefined: active_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-038 Release reset, no commands -> issue_tid = 0 every cycle from first edge, issue_valid = 1, idle = 0.
REQ-039 init_req in 3 consecutive cycles -> init_tid 1, 2, 3 with init_ack; issue then rotates 0,1,2,3,0.
REQ-040 All 8 threads ACTIVE, init_req -> init_fail = 1, init_tid = 0, thread_state unchanged.
REQ-041 Threads 0-3 ACTIVE, thread 2 sleeps -> issue sequence skips 2; wake tgt_tid=2 -> 2 re-enters rotation; wake tgt_tid=5 (FREE) -> no change.
REQ-042 stall = 1 holding issue_tid = 1, kill tgt_tid=1 -> next edge issue_valid = 0, thread_state[3:2] = 00; stall released -> next ACTIVE thread issued.
REQ-043 Kill thread 3 and init_req same cycle with threads 0-3 ACTIVE -> init_tid = 4, not 3; reset mid-sequence -> thread_state = 16'h0001.
